// File: rtl/ecko_pkg.sv
// Shared definitions for the keyword-spotting decision stage: default score
// width, an index-width helper and the scan FSM encoding.
package ecko_pkg;

    localparam int ACTIV_BITS_DEF = 8;

    // Index width for n classes; a single class still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/detect_confirm.sv
// Keyword confirmation: counts consecutive above-threshold results that agree
// on the winning class and pulses detect when the run reaches CONFIRM_FRAMES.
module detect_confirm #(
    parameter int IDX_BITS       = 6,
    parameter int ACTIV_BITS     = 8,
    parameter int CONFIRM_FRAMES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  result_i,
    input  logic [IDX_BITS-1:0]   class_idx_i,
    input  logic [ACTIV_BITS-1:0] class_score_i,
    input  logic [ACTIV_BITS-1:0] threshold_i,
    output logic                  detect_o,
    output logic [IDX_BITS-1:0]   detect_idx_o
);

    localparam logic [7:0] CONFIRM_CNT = 8'(CONFIRM_FRAMES);

    logic [7:0]          runCnt_q, runCnt_d;
    logic [IDX_BITS-1:0] runIdx_q, runIdx_d;
    logic                detect_q, detect_d;
    logic [IDX_BITS-1:0] detectIdx_q, detectIdx_d;
    logic                aboveThr;

    assign aboveThr = (class_score_i >= threshold_i);

    always_comb begin
        runCnt_d    = runCnt_q;
        runIdx_d    = runIdx_q;
        detect_d    = 1'b0;
        detectIdx_d = detectIdx_q;
        if (result_i) begin
            if (aboveThr && (class_idx_i == runIdx_q) && (runCnt_q != 8'd0)) begin
                runCnt_d = runCnt_q + 8'd1;
            end else if (aboveThr) begin
                runIdx_d = class_idx_i;
                runCnt_d = 8'd1;
            end else begin
                runCnt_d = 8'd0;
            end
            // A confirmed run re-arms from zero so the next detection needs a full new run.
            if (runCnt_d == CONFIRM_CNT) begin
                detect_d    = 1'b1;
                detectIdx_d = runIdx_d;
                runCnt_d    = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            runCnt_q    <= 8'd0;
            runIdx_q    <= '0;
            detect_q    <= 1'b0;
            detectIdx_q <= '0;
        end else begin
            runCnt_q    <= runCnt_d;
            runIdx_q    <= runIdx_d;
            detect_q    <= detect_d;
            detectIdx_q <= detectIdx_d;
        end
    end

    assign detect_o     = detect_q;
    assign detect_idx_o = detectIdx_q;

endmodule

// File: rtl/argmax_classifier.sv
// Post-classifier decision stage: buffers a score frame, scans it one class per
// cycle for the winner and runner-up, then hands the result to confirmation.
module argmax_classifier
    import ecko_pkg::*;
#(
    parameter int NUM_CLASSES    = 64,
    parameter int ACTIV_BITS     = ACTIV_BITS_DEF,
    parameter int CONFIRM_FRAMES = 3,
    localparam int IDX_BITS      = clog2_min1(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLASSES*ACTIV_BITS-1:0] data_in,
    input  logic                              data_valid,
    input  logic [ACTIV_BITS-1:0]             threshold,
    output logic                              busy,
    output logic                              result_valid,
    output logic [IDX_BITS-1:0]               class_idx,
    output logic [ACTIV_BITS-1:0]             class_score,
    output logic [ACTIV_BITS-1:0]             margin,
    output logic                              detect,
    output logic [IDX_BITS-1:0]               detect_idx,
    output logic                              overrun
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

    state_e state_q, state_d;

    logic [ACTIV_BITS-1:0] frame_q [NUM_CLASSES];
    logic [IDX_BITS-1:0]   scanIdx_q, scanIdx_d;
    logic [IDX_BITS-1:0]   bestIdx_q, bestIdx_d;
    logic [ACTIV_BITS-1:0] best_q, best_d;
    logic [ACTIV_BITS-1:0] second_q, second_d;
    logic [ACTIV_BITS-1:0] curScore;

    logic [IDX_BITS-1:0]   classIdx_q;
    logic [ACTIV_BITS-1:0] classScore_q;
    logic [ACTIV_BITS-1:0] margin_q;
    logic                  overrun_q;

    logic accept;
    logic scanLast;
    logic dropFrame;

    assign accept    = data_valid && (state_q != ST_SCAN);
    assign dropFrame = data_valid && (state_q == ST_SCAN);
    assign scanLast  = (state_q == ST_SCAN) && (scanIdx_q == LAST_IDX);
    assign curScore  = frame_q[scanIdx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (data_valid) state_d = ST_SCAN;
            ST_SCAN: if (scanLast) state_d = ST_DONE;
            ST_DONE: state_d = data_valid ? ST_SCAN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == ST_SCAN);
        result_valid = (state_q == ST_DONE);
    end

    // Strict > keeps the lower index on ties, while an equal score still becomes runner-up.
    always_comb begin
        scanIdx_d = scanIdx_q;
        bestIdx_d = bestIdx_q;
        best_d    = best_q;
        second_d  = second_q;
        if (accept) begin
            scanIdx_d = '0;
            bestIdx_d = '0;
            best_d    = '0;
            second_d  = '0;
        end else if (state_q == ST_SCAN) begin
            scanIdx_d = scanIdx_q + 1'b1;
            if (curScore > best_q) begin
                second_d  = best_q;
                best_d    = curScore;
                bestIdx_d = scanIdx_q;
            end else if (curScore > second_q) begin
                second_d = curScore;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                frame_q[k] <= data_in[k*ACTIV_BITS +: ACTIV_BITS];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scanIdx_q    <= '0;
            bestIdx_q    <= '0;
            best_q       <= '0;
            second_q     <= '0;
            classIdx_q   <= '0;
            classScore_q <= '0;
            margin_q     <= '0;
            overrun_q    <= 1'b0;
        end else begin
            scanIdx_q <= scanIdx_d;
            bestIdx_q <= bestIdx_d;
            best_q    <= best_d;
            second_q  <= second_d;
            if (scanLast) begin
                classIdx_q   <= bestIdx_d;
                classScore_q <= best_d;
                margin_q     <= best_d - second_d;
            end
            if (dropFrame) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign class_idx   = classIdx_q;
    assign class_score = classScore_q;
    assign margin      = margin_q;
    assign overrun     = overrun_q;

    detect_confirm #(
        .IDX_BITS      (IDX_BITS),
        .ACTIV_BITS    (ACTIV_BITS),
        .CONFIRM_FRAMES(CONFIRM_FRAMES)
    ) u_detect_confirm (
        .clk          (clk),
        .rst          (rst),
        .result_i     (scanLast),
        .class_idx_i  (bestIdx_d),
        .class_score_i(best_d),
        .threshold_i  (threshold),
        .detect_o     (detect),
        .detect_idx_o (detect_idx)
    );

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier with 4 classes: directed scenarios
// followed by random frames, all checked against a behavioural model.
module tb_argmax_classifier;

    localparam int NC  = 4;
    localparam int AB  = 8;
    localparam int CF  = 3;
    localparam int IB  = 2;

    logic                 clk;
    logic                 rst;
    logic [NC*AB-1:0]     data_in;
    logic                 data_valid;
    logic [AB-1:0]        threshold;
    logic                 busy;
    logic                 result_valid;
    logic [IB-1:0]        class_idx;
    logic [AB-1:0]        class_score;
    logic [AB-1:0]        margin;
    logic                 detect;
    logic [IB-1:0]        detect_idx;
    logic                 overrun;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int frameNo    = 0;

    int mRunIdx = 0;
    int mRunCnt = 0;
    int mDetIdx = 0;
    bit mOverrun = 0;
    int mIdx = 0;
    int mScore = 0;
    int mMargin = 0;

    argmax_classifier #(
        .NUM_CLASSES   (NC),
        .ACTIV_BITS    (AB),
        .CONFIRM_FRAMES(CF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .threshold   (threshold),
        .busy        (busy),
        .result_valid(result_valid),
        .class_idx   (class_idx),
        .class_score (class_score),
        .margin      (margin),
        .detect      (detect),
        .detect_idx  (detect_idx),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s frame=%0d observed=%0d expected=%0d", tag, frameNo, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Winner is the maximum, first index holding it; runner-up is the max of the rest.
    task automatic modelArgmax(input logic [31:0] frame, output int idx, output int best, output int second);
        int v [NC];
        for (int k = 0; k < NC; k++) v[k] = int'(frame[k*AB +: AB]);
        best = 0;
        for (int k = 0; k < NC; k++) if (v[k] > best) best = v[k];
        idx = 0;
        for (int k = NC - 1; k >= 0; k--) if (v[k] == best) idx = k;
        second = 0;
        for (int k = 0; k < NC; k++) if (k != idx && v[k] > second) second = v[k];
    endtask

    task automatic modelConfirm(input int idx, input int score, input int thr, output bit det);
        det = 0;
        if (score >= thr && idx == mRunIdx && mRunCnt > 0) mRunCnt++;
        else if (score >= thr) begin
            mRunIdx = idx;
            mRunCnt = 1;
        end else mRunCnt = 0;
        if (mRunCnt == CF) begin
            det = 1;
            mDetIdx = mRunIdx;
            mRunCnt = 0;
        end
    endtask

    task automatic modelReset();
        mRunIdx = 0; mRunCnt = 0; mDetIdx = 0; mOverrun = 0;
        mIdx = 0; mScore = 0; mMargin = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_rv"}, result_valid, 0);
        checkOutput({tag, "_idx"}, class_idx, 0);
        checkOutput({tag, "_score"}, class_score, 0);
        checkOutput({tag, "_margin"}, margin, 0);
        checkOutput({tag, "_detect"}, detect, 0);
        checkOutput({tag, "_detIdx"}, detect_idx, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
    endtask

    // Presents one frame in the current cycle and checks it through to its result cycle.
    task automatic applyStimulus(input logic [31:0] frame, input int thr, input int dropAt, input logic [31:0] dropFrame);
        int eIdx, eBest, eSec;
        bit eDet;
        frameNo++;
        modelArgmax(frame, eIdx, eBest, eSec);
        data_in    = frame;
        data_valid = 1'b1;
        threshold  = 8'(thr);
        step();
        data_valid = 1'b0;
        data_in    = $urandom();
        for (int c = 1; c <= NC; c++) begin
            checkOutput("busyScan", busy, 1);
            checkOutput("rvScan", result_valid, 0);
            if (c == dropAt) begin
                data_valid = 1'b1;
                data_in    = dropFrame;
                mOverrun   = 1;
            end
            step();
            data_valid = 1'b0;
        end
        modelConfirm(eIdx, eBest, thr, eDet);
        mIdx = eIdx; mScore = eBest; mMargin = eBest - eSec;
        checkOutput("rvDone", result_valid, 1);
        checkOutput("busyDone", busy, 0);
        checkOutput("classIdx", class_idx, mIdx);
        checkOutput("classScore", class_score, mScore);
        checkOutput("margin", margin, mMargin);
        checkOutput("detect", detect, eDet);
        checkOutput("detectIdx", detect_idx, mDetIdx);
        checkOutput("overrun", overrun, mOverrun);
    endtask

    task automatic idleCycle();
        step();
        checkOutput("rvIdle", result_valid, 0);
        checkOutput("detectIdle", detect, 0);
        checkOutput("busyIdle", busy, 0);
        checkOutput("idxHold", class_idx, mIdx);
        checkOutput("scoreHold", class_score, mScore);
    endtask

    task automatic resetMidScan(input logic [31:0] frame);
        frameNo++;
        data_in    = frame;
        data_valid = 1'b1;
        threshold  = 8'd20;
        step();
        data_valid = 1'b0;
        step();
        step();
        checkOutput("busyBeforeRst", busy, 1);
        rst        = 1'b1;
        data_valid = 1'b1;
        data_in    = $urandom();
        step();
        modelReset();
        checkResetState("midRst");
        rst        = 1'b0;
        data_valid = 1'b0;
        step();
        checkOutput("busyAfterRst", busy, 0);
        checkOutput("rvAfterRst", result_valid, 0);
    endtask

    logic [31:0] fr;
    logic [31:0] f90;

    initial begin
        rst        = 1'b1;
        data_valid = 1'b0;
        data_in    = '0;
        threshold  = '0;
        step();
        step();
        checkResetState("reset");
        rst = 1'b0;
        idleCycle();

        applyStimulus(pk(10, 50, 30, 5), 20, 0, 0);
        checkOutput("planIdx", class_idx, 1);
        checkOutput("planScore", class_score, 50);
        checkOutput("planMargin", margin, 20);
        idleCycle();
        applyStimulus(pk(7, 40, 40, 1), 20, 0, 0);
        checkOutput("tieIdx", class_idx, 1);
        checkOutput("tieMargin", margin, 0);
        idleCycle();
        applyStimulus(pk(0, 0, 0, 0), 20, 0, 0);
        checkOutput("zeroIdx", class_idx, 0);
        checkOutput("zeroScore", class_score, 0);
        idleCycle();

        f90 = pk(10, 20, 90, 30);
        applyStimulus(f90, 60, 0, 0);
        checkOutput("confirm1", detect, 0);
        applyStimulus(f90, 60, 0, 0);
        checkOutput("confirm2", detect, 0);
        applyStimulus(f90, 60, 0, 0);
        checkOutput("confirm3", detect, 1);
        checkOutput("confirm3Idx", detect_idx, 2);
        applyStimulus(f90, 60, 0, 0);
        checkOutput("confirm4", detect, 0);
        idleCycle();

        applyStimulus(pk(0, 0, 0, 0), 60, 0, 0);
        applyStimulus(f90, 60, 0, 0);
        applyStimulus(f90, 60, 0, 0);
        applyStimulus(pk(10, 20, 30, 95), 60, 0, 0);
        applyStimulus(f90, 60, 0, 0);
        checkOutput("breakWinner", detect, 0);
        applyStimulus(f90, 60, 0, 0);
        applyStimulus(pk(10, 20, 50, 30), 60, 0, 0);
        applyStimulus(f90, 60, 0, 0);
        applyStimulus(f90, 60, 0, 0);
        checkOutput("breakThr", detect, 0);
        applyStimulus(f90, 60, 0, 0);
        checkOutput("afterBreakDet", detect, 1);
        idleCycle();

        applyStimulus(pk(100, 20, 30, 40), 60, 2, pk(0, 0, 0, 250));
        checkOutput("dropIdx", class_idx, 0);
        checkOutput("dropScore", class_score, 100);
        checkOutput("dropOverrun", overrun, 1);
        applyStimulus(pk(1, 2, 3, 200), 60, 0, 0);
        checkOutput("b2bIdx", class_idx, 3);
        checkOutput("overrunSticky", overrun, 1);
        idleCycle();

        resetMidScan(pk(5, 6, 7, 8));
        applyStimulus(pk(10, 50, 30, 5), 20, 0, 0);
        checkOutput("freshIdx", class_idx, 1);
        idleCycle();

        for (int n = 0; n < 40; n++) begin
            int fav;
            fav = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) fav = $urandom_range(0, 3);
            fr = pk($urandom_range(0, 127), $urandom_range(0, 127),
                    $urandom_range(0, 127), $urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) fr[fav*AB +: AB] = 8'($urandom_range(100, 255));
            if ($urandom_range(0, 7) == 0) fr[((fav + 1) % NC)*AB +: AB] = fr[fav*AB +: AB];
            applyStimulus(fr, $urandom_range(60, 140), 0, 0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idleCycle();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
